// File: rtl/slv_fsm_mux.sv
// Request/ack bridge from one register master to SLV_NUM slave channels.
// Registered response stage, access timeout and bad-select/bad-command errors.
module slv_fsm_mux #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int SLV_NUM    = 4,
  parameter int SEL_WIDTH  = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          mst__fsm__req_vld,
  output logic                          fsm__mst__req_rdy,
  input  logic                          mst__fsm__rd_en,
  input  logic                          mst__fsm__wr_en,
  input  logic [ADDR_WIDTH-1:0]         mst__fsm__addr,
  input  logic [DATA_WIDTH-1:0]         mst__fsm__wr_data,
  input  logic [SEL_WIDTH-1:0]          mst__fsm__sel,
  input  logic                          mst__fsm__sync_reset,
  output logic                          fsm__mst__ack_vld,
  input  logic                          mst__fsm__ack_rdy,
  output logic [DATA_WIDTH-1:0]         fsm__mst__rd_data,
  output logic                          fsm__mst__err,
  output logic [SLV_NUM-1:0]            fsm__slv__req_vld,
  input  logic [SLV_NUM-1:0]            slv__fsm__req_rdy,
  output logic [ADDR_WIDTH-1:0]         fsm__slv__addr,
  output logic [DATA_WIDTH-1:0]         fsm__slv__wr_data,
  output logic                          fsm__slv__wr_en,
  output logic                          fsm__slv__rd_en,
  output logic [SLV_NUM-1:0]            fsm__slv__ack_rdy,
  input  logic [SLV_NUM-1:0]            slv__fsm__ack_vld,
  input  logic [SLV_NUM*DATA_WIDTH-1:0] slv__fsm__rd_data,
  output logic                          fsm__slv__sync_reset
);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, WAIT_ACK, RESP} state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic                    rd_q, rd_d, wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [SLV_NUM-1:0]      sel_oh;
  logic                    sel_rdy, sel_ack, timeout_hit, req_bad, busy;
  logic [DATA_WIDTH-1:0]   sel_data;

  // Only the latched channel is ever looked at; other slaves are masked out.
  always_comb begin
    sel_oh   = '0;
    sel_data = '0;
    for (int i = 0; i < SLV_NUM; i++) begin
      sel_oh[i] = (sel_q == SEL_WIDTH'(i));
      if (sel_oh[i]) sel_data = slv__fsm__rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    sel_rdy = |(sel_oh & slv__fsm__req_rdy);
    sel_ack = |(sel_oh & slv__fsm__ack_vld);
  end

  assign req_bad     = (int'(mst__fsm__sel) >= SLV_NUM) || (mst__fsm__rd_en == mst__fsm__wr_en);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mst__fsm__req_vld) begin
          addr_d  = mst__fsm__addr;
          wdata_d = mst__fsm__wr_data;
          sel_d   = mst__fsm__sel;
          rd_d    = mst__fsm__rd_en;
          wr_d    = mst__fsm__wr_en;
          cnt_d   = '0;
          if (req_bad) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = WAIT_RDY;
          end
        end
      end
      WAIT_RDY, WAIT_ACK: begin
        // Saturate so a handshake past the limit cannot wrap into a late timeout.
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
        if ((state_q == WAIT_RDY) && sel_rdy && !sel_ack) begin
          state_d = WAIT_ACK;
        end else if (sel_ack && (sel_rdy || state_q == WAIT_ACK)) begin
          state_d = RESP;
          rdata_d = rd_q ? sel_data : '0;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      RESP: if (mst__fsm__ack_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (mst__fsm__sync_reset) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy                 = (state_q == WAIT_RDY) || (state_q == WAIT_ACK);
  assign fsm__mst__req_rdy    = (state_q == IDLE) && rstn;
  assign fsm__mst__ack_vld    = (state_q == RESP);
  assign fsm__mst__rd_data    = (state_q == RESP) ? rdata_q : '0;
  assign fsm__mst__err        = (state_q == RESP) && err_q;
  assign fsm__slv__req_vld    = (state_q == WAIT_RDY) ? sel_oh : '0;
  assign fsm__slv__ack_rdy    = (state_q == WAIT_ACK) ? sel_oh : '0;
  assign fsm__slv__addr       = busy ? addr_q : '0;
  assign fsm__slv__wr_data    = busy ? wdata_q : '0;
  assign fsm__slv__wr_en      = busy && wr_q;
  assign fsm__slv__rd_en      = busy && rd_q;
  assign fsm__slv__sync_reset = mst__fsm__sync_reset;

endmodule
